branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences the front end after a branch or jump resolves in EX of the five-stage pipeline. The pipeline predicts not-taken. When EX reports a taken branch, this block kills the wrong-path instructions and steers the PC to the target. If instruction memory is busy, it holds the redirect until memory is free. It also owns the sticky halt state of fetch and keeps a saturating count of redirects for the performance counters.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX holds a real (non-bubble) instruction.
- ex_branch  input  1  the EX instruction is a conditional branch or a jump.
- brch_cnd  input  1  branch-condition result for the EX instruction (1 = taken; always 1 for a jump).
- ex_stall  input  1  EX is stalled this cycle; its instruction does not advance.
- ex_target  input  16  target address computed in EX.
- imem_busy  input  1  instruction memory cannot accept a new fetch address this cycle.
- halt  input  1  EX holds a valid HALT.
- pc_redirect  output  1  one-cycle pulse: load redirect_pc into the PC.
- redirect_pc  output  16  redirect address; meaningful only while pc_redirect=1.
- flush_fetch  output  1  squash the IF/ID register at the next edge.
- flush_decode  output  1  squash the ID/EX register at the next edge.
- fetch_hold  output  1  freeze the PC and suppress fetch.
- misalign_err  output  1  one-cycle pulse: the accepted target had bit 0 set.
- redirect_count  output  16  number of redirects issued; saturates.

## Operation
- States are IDLE, PEND and HALTED. The state and the held target (pend_pc, 16 bits) are registers.
- A redirect is accepted in a cycle when all of these hold: ex_valid=1, ex_branch=1, brch_cnd=1, ex_stall=0.

IDLE:
- When a redirect is accepted, flush_fetch=1 and flush_decode=1 in that same cycle. These outputs are combinational.
- If imem_busy=0 in that cycle: pc_redirect=1, redirect_pc = {ex_target[15:1],1'b0}, redirect_count increments, and the state stays IDLE.
- If imem_busy=1 in that cycle: pend_pc <= {ex_target[15:1],1'b0} and the state goes to PEND. pc_redirect stays 0.
- misalign_err=1 in the accept cycle when ex_target[0]=1. The PC is still redirected to the aligned address.
- When halt=1 and no redirect is accepted, the state goes to HALTED. Halt is ignored when a redirect is accepted in the same cycle.

PEND:
- fetch_hold=1 and flush_fetch=1 every cycle. flush_decode=0.
- When imem_busy=0: pc_redirect=1, redirect_pc = pend_pc, redirect_count increments, and the state goes to IDLE.
- ex_* inputs and halt are ignored in this state.

HALTED:
- fetch_hold=1. All other outputs are 0.
- The only exit is rst.

redirect_count:
- Increments by 1 on every pc_redirect pulse.
- Holds at 16'hFFFF once reached; it does not wrap.

## Timing
- Reset:
  - The state goes to IDLE; pend_pc = 0; redirect_count = 0.
  - While rst=1, every output is 0, including the combinational ones.
  - A reset in PEND drops the pending redirect.
- Flush and redirect latency when imem is free is 0 cycles: the outputs are in the resolve cycle and the PC loads at the next edge. The first target fetch is resolve+1.
- With imem busy for k cycles after the resolve cycle, pc_redirect pulses in cycle resolve+k+1. Fetch is held for the k+1 intervening cycles.
- ex_stall=1 blocks acceptance. The branch is accepted exactly once, in the first cycle it is unstalled.
- Entry to HALTED takes effect at the edge after halt is sampled. fetch_hold rises in the next cycle.
- At most one redirect is pending at any time.

## Test plan
- Taken branch, memory free:
  - Stimulus: ex_valid=1, ex_branch=1, brch_cnd=1, ex_target=16'h0040, imem_busy=0.
  - Required: same cycle pc_redirect=1, redirect_pc=16'h0040, both flushes=1; next cycle all 0 and redirect_count=1.
- Not-taken branch:
  - Stimulus: brch_cnd=0.
  - Required: no flush, no redirect, count unchanged.
- Busy memory:
  - Stimulus: target 16'h1234; imem_busy=1 in the resolve cycle and for 3 more cycles.
  - Required: resolve cycle flush_fetch=1, flush_decode=1, pc_redirect=0.
  - Required: the next 3 cycles fetch_hold=1, flush_fetch=1.
  - Required: in the 4th cycle after resolve, imem_busy drops; pc_redirect=1 with redirect_pc=16'h1234; IDLE the following cycle.
- Stall and misalignment:
  - Stimulus: ex_stall=1 for 2 cycles, then released; target 16'h0081.
  - Required: a single redirect in the release cycle, redirect_pc=16'h0080, misalign_err pulse.
- Halt interactions:
  - Stimulus: halt with a taken branch in the same cycle. Required: the redirect happens and the state stays IDLE.
  - Stimulus: a later halt alone. Required: fetch_hold stays 1 until rst.
  - Stimulus: rst asserted while in PEND. Required: all outputs 0 and no redirect afterward.
- Saturation:
  - Stimulus: preload the count to 16'hFFFE via 65534 redirects (or force), then issue 3 more.
  - Required: the count reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: front-end sequencing after a taken branch/jump resolves in EX.
// Kills wrong-path fetches, steers the PC to the target (deferring it while
// instruction memory is busy), owns the sticky fetch halt, and counts redirects.
module branch_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_branch,
  input  logic        brch_cnd,
  input  logic        ex_stall,
  input  logic [15:0] ex_target,
  input  logic        imem_busy,
  input  logic        halt,
  output logic        pc_redirect,
  output logic [15:0] redirect_pc,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        fetch_hold,
  output logic        misalign_err,
  output logic [15:0] redirect_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [15:0] pendPc;
  logic [15:0] nextPendPc;
  logic [15:0] countQ;
  logic        accept;
  logic [15:0] alignedTarget;

  assign accept        = ex_valid & ex_branch & brch_cnd & ~ex_stall;
  assign alignedTarget = {ex_target[15:1], 1'b0};

  // State, held target and saturating redirect counter; all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pendPc <= 16'h0000;
      countQ <= 16'h0000;
    end else begin
      state  <= nextState;
      pendPc <= nextPendPc;
      if (pc_redirect && (countQ != 16'hFFFF)) begin
        countQ <= countQ + 16'h0001;
      end
    end
  end

  // Next-state and output decode; everything stays quiet while reset is held.
  always_comb begin
    nextState    = state;
    nextPendPc   = pendPc;
    pc_redirect  = 1'b0;
    redirect_pc  = 16'h0000;
    flush_fetch  = 1'b0;
    flush_decode = 1'b0;
    fetch_hold   = 1'b0;
    misalign_err = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
            misalign_err = ex_target[0];
            if (!imem_busy) begin
              pc_redirect = 1'b1;
              redirect_pc = alignedTarget;
            end else begin
              nextPendPc = alignedTarget;
              nextState  = PEND;
            end
          end else if (halt) begin
            nextState = HALTED;
          end
        end
        PEND: begin
          fetch_hold  = 1'b1;
          flush_fetch = 1'b1;
          if (!imem_busy) begin
            pc_redirect = 1'b1;
            redirect_pc = pendPc;
            nextState   = IDLE;
          end
        end
        HALTED: begin
          fetch_hold = 1'b1;
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
  end

  // The counter output reads zero while reset is asserted, like every other output.
  always_comb begin
    redirect_count = rst ? 16'h0000 : countQ;
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed testbench for branch_redirect_ctrl with hand-computed expectations.
module tb_branch_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_branch;
  logic        brch_cnd;
  logic        ex_stall;
  logic [15:0] ex_target;
  logic        imem_busy;
  logic        halt;
  logic        pc_redirect;
  logic [15:0] redirect_pc;
  logic        flush_fetch;
  logic        flush_decode;
  logic        fetch_hold;
  logic        misalign_err;
  logic [15:0] redirect_count;

  int checkCount;
  int errorCount;

  branch_redirect_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .brch_cnd       (brch_cnd),
    .ex_stall       (ex_stall),
    .ex_target      (ex_target),
    .imem_busy      (imem_busy),
    .halt           (halt),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc),
    .flush_fetch    (flush_fetch),
    .flush_decode   (flush_decode),
    .fetch_hold     (fetch_hold),
    .misalign_err   (misalign_err),
    .redirect_count (redirect_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic r, input logic v, input logic b, input logic c,
                               input logic s, input logic [15:0] tgt, input logic busy,
                               input logic h);
    @(negedge clk);
    rst       = r;
    ex_valid  = v;
    ex_branch = b;
    brch_cnd  = c;
    ex_stall  = s;
    ex_target = tgt;
    imem_busy = busy;
    halt      = h;
    #1;
  endtask

  // Checks the full output set for the current cycle.
  task automatic checkAll(input string tag, input logic pr, input logic [15:0] rpc,
                          input logic ff, input logic fd, input logic fh, input logic me,
                          input logic [15:0] cnt);
    checkOutput({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, pr});
    if (pr) checkOutput({tag, ".redirect_pc"}, {16'd0, redirect_pc}, {16'd0, rpc});
    checkOutput({tag, ".flush_fetch"}, {31'd0, flush_fetch}, {31'd0, ff});
    checkOutput({tag, ".flush_decode"}, {31'd0, flush_decode}, {31'd0, fd});
    checkOutput({tag, ".fetch_hold"}, {31'd0, fetch_hold}, {31'd0, fh});
    checkOutput({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, me});
    checkOutput({tag, ".redirect_count"}, {16'd0, redirect_count}, {16'd0, cnt});
  endtask

  // Directed sequence covering each scenario in turn.
  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1; ex_valid = 1'b0; ex_branch = 1'b0; brch_cnd = 1'b0; ex_stall = 1'b0;
    ex_target = 16'h0000; imem_busy = 1'b0; halt = 1'b0;

    // Reset held with a taken branch and halt on the inputs: everything must stay 0.
    applyStimulus(1, 1, 1, 1, 0, 16'h0041, 0, 1);
    checkAll("reset", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

    // Taken branch, memory free.
    applyStimulus(0, 1, 1, 1, 0, 16'h0040, 0, 0);
    checkAll("takenFree", 1, 16'h0040, 1, 1, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("takenFreeAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0001);

    // Not-taken branch.
    applyStimulus(0, 1, 1, 0, 0, 16'h0200, 0, 0);
    checkAll("notTaken", 0, 16'h0000, 0, 0, 0, 0, 16'h0001);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("notTakenAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0001);

    // Busy memory for the resolve cycle plus 3; EX inputs and halt ignored while pending.
    applyStimulus(0, 1, 1, 1, 0, 16'h1234, 1, 0);
    checkAll("busyResolve", 0, 16'h0000, 1, 1, 0, 0, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 16'h5555, 1, 1);
      checkAll("busyPend", 0, 16'h0000, 1, 0, 1, 0, 16'h0001);
    end
    applyStimulus(0, 1, 1, 1, 0, 16'h5555, 0, 1);
    checkAll("busyRelease", 1, 16'h1234, 1, 0, 1, 0, 16'h0001);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("busyAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0002);

    // Stalled branch with misaligned target, accepted once on release.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 1, 1, 16'h0081, 0, 0);
      checkAll("stalled", 0, 16'h0000, 0, 0, 0, 0, 16'h0002);
    end
    applyStimulus(0, 1, 1, 1, 0, 16'h0081, 0, 0);
    checkAll("stallRelease", 1, 16'h0080, 1, 1, 0, 1, 16'h0002);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("stallAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0003);

    // Halt together with a taken branch: redirect wins, stays IDLE.
    applyStimulus(0, 1, 1, 1, 0, 16'h0100, 0, 1);
    checkAll("haltWithBranch", 1, 16'h0100, 1, 1, 0, 0, 16'h0003);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("haltWithBranchAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0004);

    // Reset while pending drops the redirect.
    applyStimulus(0, 1, 1, 1, 0, 16'h0300, 1, 0);
    checkAll("pendResolve", 0, 16'h0000, 1, 1, 0, 0, 16'h0004);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 1, 0);
    checkAll("pendHold", 0, 16'h0000, 1, 0, 1, 0, 16'h0004);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("pendReset", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
      checkAll("pendResetAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    end

    // Halt alone: sticky until reset, later branches ignored.
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 1);
    checkAll("haltSample", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 1, 1, 0, 16'h0400, 0, 0);
    checkAll("halted", 0, 16'h0000, 0, 0, 1, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("haltedStill", 0, 16'h0000, 0, 0, 1, 0, 16'h0000);
    applyStimulus(1, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("haltReset", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("haltResetAfter", 0, 16'h0000, 0, 0, 0, 0, 16'h0000);

    // Saturation: 65534 back-to-back redirects, then 3 more.
    for (int i = 0; i < 65534; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 16'h0010, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("satPreload", 0, 16'h0000, 0, 0, 0, 0, 16'hFFFE);
    applyStimulus(0, 1, 1, 1, 0, 16'h0020, 0, 0);
    checkAll("satRedirect1", 1, 16'h0020, 1, 1, 0, 0, 16'hFFFE);
    applyStimulus(0, 1, 1, 1, 0, 16'h0020, 0, 0);
    checkAll("satRedirect2", 1, 16'h0020, 1, 1, 0, 0, 16'hFFFF);
    applyStimulus(0, 1, 1, 1, 0, 16'h0020, 0, 0);
    checkAll("satRedirect3", 1, 16'h0020, 1, 1, 0, 0, 16'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 16'h0000, 0, 0);
    checkAll("satHold", 0, 16'h0000, 0, 0, 0, 0, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
